// File: rtl/dtcm_bus.sv
// dtcm_bus: data tightly-coupled memory behind a valid/ready request/response
// interface. Accepts byte addresses with RISC-V funct3 access types, steers
// store bytes onto lanes, sign/zero-extends load data, flags misaligned or
// illegal accesses, and optionally sweeps the array to zero after reset.
//
// Ports:
//   CLK, RST              clock; synchronous active-high reset
//   REQ_VALID/REQ_READY   request handshake
//   REQ_WE                1 = store, 0 = load
//   REQ_ADDR[AW+1:0]      byte address
//   REQ_TYPE[2:0]         funct3 (B, H, W, BU, HU)
//   REQ_WDATA[31:0]       right-aligned store data
//   RSP_VALID/RSP_READY   response handshake
//   RSP_RDATA[31:0]       extended load data (0 for stores and errors)
//   RSP_ERR               access was misaligned or illegal
module dtcm_bus #(
  parameter int unsigned AW             = 10,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          REQ_VALID,
  output logic          REQ_READY,
  input  logic          REQ_WE,
  input  logic [AW+1:0] REQ_ADDR,
  input  logic [2:0]    REQ_TYPE,
  input  logic [31:0]   REQ_WDATA,
  output logic          RSP_VALID,
  input  logic          RSP_READY,
  output logic [31:0]   RSP_RDATA,
  output logic          RSP_ERR
);

  localparam int unsigned DEPTH = 2 ** AW;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    RESP
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] clr_cnt;

  logic          accept;
  logic [AW-1:0] word_idx;
  logic [1:0]    off;
  logic          legal;
  logic [3:0]    st_mask;
  logic [31:0]   st_data;

  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [3:0]    wr_mask;
  logic [31:0]   wr_data;

  logic [31:0]   rd_word;
  logic [2:0]    rsp_type;
  logic [1:0]    rsp_off;
  logic          rsp_load;
  logic          rsp_err;
  logic [31:0]   shifted;
  logic [31:0]   extended;

  assign word_idx = REQ_ADDR[AW+1:2];
  assign off      = REQ_ADDR[1:0];
  assign accept   = REQ_VALID & REQ_READY;

  // Access legality and store lane steering
  always_comb begin
    legal = 1'b0;
    case (REQ_TYPE)
      3'b000, 3'b100: legal = 1'b1;
      3'b001, 3'b101: legal = ~off[0];
      3'b010:         legal = (off == 2'b00);
      default:        legal = 1'b0;
    endcase
    // Unsigned variants only exist for loads
    if (REQ_WE && REQ_TYPE[2]) legal = 1'b0;

    case (REQ_TYPE[1:0])
      2'b00:   st_mask = 4'b0001 << off;
      2'b01:   st_mask = 4'b0011 << off;
      default: st_mask = 4'b1111;
    endcase
    st_data = REQ_WDATA << {off, 3'b000};
  end

  // Next state and handshake outputs
  always_comb begin
    state_nxt = state;
    REQ_READY = 1'b0;
    RSP_VALID = 1'b0;
    case (state)
      INIT: begin
        if (clr_cnt == '1) state_nxt = IDLE;
      end
      IDLE: begin
        REQ_READY = 1'b1;
        if (REQ_VALID) state_nxt = RESP;
      end
      RESP: begin
        RSP_VALID = 1'b1;
        REQ_READY = RSP_READY;
        if (RSP_READY && !REQ_VALID) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Single write port shared by the clear sweep and legal stores;
  // reset suppresses any write on its edge.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = word_idx;
    wr_mask = st_mask;
    wr_data = st_data;
    if (state == INIT) begin
      wr_en   = 1'b1;
      wr_idx  = clr_cnt;
      wr_mask = '1;
      wr_data = '0;
    end else if (accept && REQ_WE && legal) begin
      wr_en = 1'b1;
    end
    if (RST) wr_en = 1'b0;
  end

  // One independent byte-wide array per lane; each lane has its own
  // registered read so the four bytes of a word are captured together.
  for (genvar n = 0; n < 4; n++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    logic [7:0] lane_rd;

    always_ff @(posedge CLK) begin
      if (wr_en && wr_mask[n]) lane_mem[wr_idx] <= wr_data[8*n +: 8];
      if (accept && !REQ_WE)   lane_rd <= lane_mem[word_idx];
    end
  end

  assign rd_word = {g_lane[3].lane_rd, g_lane[2].lane_rd,
                    g_lane[1].lane_rd, g_lane[0].lane_rd};

  // Control state and response attributes
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= CLEAR_ON_RESET ? INIT : IDLE;
      clr_cnt  <= '0;
      rsp_load <= 1'b0;
      rsp_err  <= 1'b0;
      rsp_type <= '0;
      rsp_off  <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) clr_cnt <= clr_cnt + AW'(1);
      if (accept) begin
        rsp_load <= !REQ_WE && legal;
        rsp_err  <= !legal;
        rsp_type <= REQ_TYPE;
        rsp_off  <= off;
      end
    end
  end

  // Load extraction from the registered word; held stable while in RESP
  always_comb begin
    shifted = rd_word >> {rsp_off, 3'b000};
    case (rsp_type)
      3'b000:  extended = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  extended = {24'h0, shifted[7:0]};
      3'b001:  extended = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  extended = {16'h0, shifted[15:0]};
      default: extended = shifted;
    endcase
    RSP_RDATA = rsp_load ? extended : '0;
    RSP_ERR   = rsp_err;
  end

endmodule
